// File: rtl/axi2apb_cmd_ctrl.sv
// Command sequencer of the AXI-to-APB bridge: round-robin AR/AW arbitration, one APB3
// transfer per command, and the active command's id/address/error for the response datapaths.
module axi2apb_cmd_ctrl #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [AXI_ID_WIDTH-1:0]     AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                  AWLEN,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AXI_ID_WIDTH-1:0]     ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                  ARLEN,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic                        WLAST,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [31:0]                 pwdata,
  input  logic                        pready,
  output logic [AXI_ID_WIDTH-1:0]     cmd_id,
  output logic [APB_ADDR_WIDTH+3:0]   cmd_addr,
  output logic                        cmd_err,
  input  logic                        finish_rd,
  input  logic                        finish_wr
);

  localparam int LANES       = AXI_DATA_WIDTH / 32;
  localparam int EXTRA_LANES = $clog2(LANES);

  typedef enum logic [2:0] {IDLE, WAIT_W, SETUP, ACCESS, RESP} state_t;

  state_t      state;
  logic        last_grant_wr;
  logic        w_first;
  logic        grant_rd;
  logic        grant_wr;
  logic        finish;
  logic [31:0] wlane_data;
  logic        unused_addr_bits;

  // A tie goes to whichever channel did not win last time.
  assign grant_rd = ARVALID && (!AWVALID || last_grant_wr);
  assign grant_wr = AWVALID && (!ARVALID || !last_grant_wr);

  assign ARREADY = rstn && (state == IDLE) && grant_rd;
  assign AWREADY = rstn && (state == IDLE) && grant_wr;
  assign WREADY  = (state == WAIT_W);
  assign paddr   = {cmd_addr[APB_ADDR_WIDTH-1:2], 2'b00};
  assign finish  = pwrite ? finish_wr : finish_rd;

  assign unused_addr_bits = ^{ARADDR, AWADDR};

  generate
    if (EXTRA_LANES > 0) begin : g_lane_sel
      logic [31:0] wlane [LANES];
      for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign wlane[g] = WDATA[32*g +: 32];
      end
      assign wlane_data = wlane[cmd_addr[2 +: EXTRA_LANES]];
    end else begin : g_single_lane
      assign wlane_data = WDATA[31:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      last_grant_wr <= 1'b1;
      w_first       <= 1'b0;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      pwdata        <= '0;
      cmd_id        <= '0;
      cmd_addr      <= '0;
      cmd_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state         <= SETUP;
            psel          <= 1'b1;
            last_grant_wr <= 1'b0;
            pwrite        <= 1'b0;
            cmd_id        <= ARID;
            cmd_addr      <= ARADDR[APB_ADDR_WIDTH+3:0];
            cmd_err       <= (ARLEN != 8'd0);
          end else if (grant_wr) begin
            state         <= WAIT_W;
            w_first       <= 1'b1;
            last_grant_wr <= 1'b1;
            pwrite        <= 1'b1;
            cmd_id        <= AWID;
            cmd_addr      <= AWADDR[APB_ADDR_WIDTH+3:0];
            cmd_err       <= (AWLEN != 8'd0);
          end
        end
        // Only the first beat carries the APB data; trailing beats of a burst are drained.
        WAIT_W: begin
          if (WVALID) begin
            w_first <= 1'b0;
            if (w_first) pwdata <= wlane_data;
            if (WLAST) begin
              state <= SETUP;
              psel  <= 1'b1;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state   <= RESP;
            psel    <= 1'b0;
            penable <= 1'b0;
          end
        end
        RESP: begin
          if (finish) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2apb_cmd_ctrl.sv
// Self-checking bench for axi2apb_cmd_ctrl: vector table, hand-written corner sequences and
// randomized commands predicted by a transaction-level model.
module tb_axi2apb_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  AWID, ARID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [63:0] WDATA;
  logic        WLAST, WVALID, WREADY;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [5:0]  cmd_id;
  logic [15:0] cmd_addr;
  logic        cmd_err;
  logic        finish_rd, finish_wr;

  always #5 clk = ~clk;

  axi2apb_cmd_ctrl dut (
    .clk(clk), .rstn(rstn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_err(cmd_err),
    .finish_rd(finish_rd), .finish_wr(finish_wr)
  );

  typedef struct {
    logic        rd_v;
    logic        wr_v;
    logic [5:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [63:0] d0;
    int          stall;
    logic        exp_wr;
    logic [11:0] exp_paddr;
    logic [15:0] exp_caddr;
    logic [31:0] exp_pwdata;
    logic        exp_err;
  } cmd_t;

  int   checks   = 0;
  int   failures = 0;
  logic model_last_wr;
  cmd_t tbl [6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Transaction-level prediction: arbitration winner, APB address, data lane and error flag.
  function automatic cmd_t predict(input cmd_t c);
    cmd_t r = c;
    if (c.rd_v && c.wr_v) r.exp_wr = !model_last_wr;
    else                  r.exp_wr = c.wr_v;
    r.exp_paddr  = 12'(((c.addr % 4096) / 4) * 4);
    r.exp_caddr  = 16'(c.addr % 65536);
    r.exp_pwdata = 32'(c.d0 >> (32 * ((c.addr / 4) % 2)));
    r.exp_err    = (c.len != 8'd0);
    return r;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    ARVALID = 0; AWVALID = 0; WVALID = 0; WLAST = 0; pready = 0;
    finish_rd = 0; finish_wr = 0;
    ARID = '0; AWID = '0; ARADDR = '0; AWADDR = '0; ARLEN = '0; AWLEN = '0; WDATA = '0;
    @(negedge clk); @(negedge clk); #1;
    check("reset ctrl outputs", {ARREADY, AWREADY, WREADY, psel, penable, pwrite, cmd_err}, 0);
    check("reset paddr/pwdata", {paddr, pwdata}, 0);
    check("reset cmd id/addr", {cmd_id, cmd_addr}, 0);
    @(negedge clk);
    rstn = 1'b1;
    model_last_wr = 1'b1;
  endtask

  // Runs one command from an idle DUT, starting and ending on a falling edge.
  task automatic run_cmd(input string nm, input cmd_t c);
    if (c.rd_v) begin ARVALID = 1; ARID = c.id; ARADDR = c.addr; ARLEN = c.len; end
    if (c.wr_v) begin AWVALID = 1; AWID = c.id; AWADDR = c.addr; AWLEN = c.len; end
    #1;
    check({nm, " ARREADY"}, ARREADY, !c.exp_wr);
    check({nm, " AWREADY"}, AWREADY, c.exp_wr);
    model_last_wr = c.exp_wr;
    @(negedge clk);
    ARVALID = 0; AWVALID = 0;
    if (c.exp_wr) begin
      for (int b = 0; b <= int'(c.len); b++) begin
        WVALID = 1;
        WDATA  = (b == 0) ? c.d0 : {$urandom, $urandom};
        WLAST  = (b == int'(c.len));
        #1 check({nm, " WREADY"}, WREADY, 1);
        @(negedge clk);
      end
      WVALID = 0; WLAST = 0;
    end
    #1;
    check({nm, " SETUP psel/penable"}, {psel, penable}, 2'b10);
    check({nm, " paddr"}, paddr, c.exp_paddr);
    check({nm, " pwrite"}, pwrite, c.exp_wr);
    check({nm, " cmd_id"}, cmd_id, c.id);
    check({nm, " cmd_addr"}, cmd_addr, c.exp_caddr);
    check({nm, " cmd_err"}, cmd_err, c.exp_err);
    if (c.exp_wr) check({nm, " pwdata"}, pwdata, c.exp_pwdata);
    @(negedge clk);
    for (int n = 0; n <= c.stall; n++) begin
      pready = (n == c.stall);
      #1;
      check({nm, " ACCESS psel/penable"}, {psel, penable}, 2'b11);
      check({nm, " ACCESS paddr"}, paddr, c.exp_paddr);
      @(negedge clk);
    end
    pready = 0;
    #1;
    check({nm, " RESP psel/penable"}, {psel, penable}, 2'b00);
    check({nm, " RESP cmd_id"}, cmd_id, c.id);
    if (c.exp_wr) check({nm, " RESP pwdata"}, pwdata, c.exp_pwdata);
    ARVALID = 1; ARID = '0; ARADDR = '0; ARLEN = '0;
    if (c.exp_wr) finish_rd = 1; else finish_wr = 1;
    #1 check({nm, " held in RESP"}, ARREADY, 0);
    @(negedge clk);
    finish_rd = 0; finish_wr = 0;
    if (c.exp_wr) finish_wr = 1; else finish_rd = 1;
    #1 check({nm, " other finish ignored"}, ARREADY, 0);
    @(negedge clk);
    ARVALID = 0; finish_rd = 0; finish_wr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   grants;
    int   xfers;
    logic exp_rr_wr;
    cmd_t c;

    tbl[0] = '{1'b1, 1'b0, 6'd5,  32'h0000_0A04, 8'd0, 64'd0,                  0, 1'b0, 12'hA04, 16'h0A04, 32'h0,         1'b0};
    tbl[1] = '{1'b0, 1'b1, 6'd3,  32'h0000_010C, 8'd0, 64'h1111_2222_3333_4444, 0, 1'b1, 12'h10C, 16'h010C, 32'h1111_2222, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 6'd9,  32'h0000_5FFF, 8'd0, 64'd0,                  3, 1'b0, 12'hFFC, 16'h5FFF, 32'h0,         1'b0};
    tbl[3] = '{1'b0, 1'b1, 6'h2A, 32'h0000_0208, 8'd3, 64'hAAAA_BBBB_CCCC_DDDD, 1, 1'b1, 12'h208, 16'h0208, 32'hCCCC_DDDD, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 6'h3F, 32'hFFFF_F000, 8'd0, 64'd0,                  0, 1'b0, 12'h000, 16'hF000, 32'h0,         1'b0};
    tbl[5] = '{1'b1, 1'b1, 6'h11, 32'h0000_0014, 8'd1, 64'h5555_6666_7777_8888, 2, 1'b1, 12'h014, 16'h0014, 32'h5555_6666, 1'b1};

    do_reset();
    for (int i = 0; i < 6; i++) run_cmd($sformatf("vec%0d", i), tbl[i]);

    // Both channels held valid: grants must alternate R,W,R,W with one APB transfer each.
    do_reset();
    ARVALID = 1; AWVALID = 1; ARID = 6'd1; AWID = 6'd2;
    ARADDR = 32'h40; AWADDR = 32'h80; ARLEN = 0; AWLEN = 0;
    WVALID = 1; WLAST = 1; WDATA = '1; pready = 1; finish_rd = 1; finish_wr = 1;
    grants = 0; xfers = 0; exp_rr_wr = 1'b0;
    for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
      #1;
      if (ARREADY || AWREADY) begin
        check("rr single ready", ARREADY && AWREADY, 0);
        check("rr grant order", AWREADY, exp_rr_wr);
        check("rr no APB overlap", psel, 0);
        if (grants > 0) check("rr one xfer per grant", xfers, 1);
        grants++;
        xfers = 0;
        exp_rr_wr = !exp_rr_wr;
      end
      if (psel && penable && pready) xfers++;
      @(negedge clk);
    end
    check("rr grant count", grants, 4);

    // Reset asserted in the middle of an ACCESS phase.
    do_reset();
    ARVALID = 1; ARID = 6'd7; ARADDR = 32'h123; ARLEN = 0;
    #1 check("rst6 grant", ARREADY, 1);
    @(negedge clk); ARVALID = 0;
    @(negedge clk); #1;
    check("rst6 in ACCESS", {psel, penable}, 2'b11);
    ARVALID = 1;
    #2 rstn = 0;
    #1;
    check("rst6 async apb drop", {psel, penable}, 2'b00);
    check("rst6 async ready drop", {ARREADY, AWREADY, WREADY}, 3'b000);
    @(negedge clk);
    ARVALID = 0;
    @(negedge clk);
    rstn = 1; model_last_wr = 1'b1;
    c = '{1'b1, 1'b0, 6'd12, 32'h0000_0F30, 8'd0, 64'd0, 1, 1'b0, 12'h0, 16'h0, 32'h0, 1'b0};
    c = predict(c);
    run_cmd("rst6 after release", c);

    for (int i = 0; i < 40; i++) begin
      int kind;
      kind   = int'($urandom_range(0, 2));
      c.rd_v = (kind != 1);
      c.wr_v = (kind != 0);
      c.id   = 6'($urandom);
      c.addr = $urandom;
      c.len  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
      c.d0   = {$urandom, $urandom};
      c.stall = int'($urandom_range(0, 3));
      c = predict(c);
      run_cmd($sformatf("rnd%0d", i), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
